// File: rtl/db_ram_arb_pkg.sv
// Shared widths, state encoding and helpers for the deblocking SRAM port-A arbiter.
package db_ram_arb_pkg;
  localparam int DB_RAM_AW = 5;
  localparam int DB_RAM_DW = 128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/db_ram_arb_rr_pick.sv
// Round-robin priority encoder: one-hot grant of the first request at or after ptr_i.
module rr_pick
  import db_ram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW-1:0] v_idx;
  logic          v_found;

  always_comb begin
    gnt_o   = '0;
    v_found = 1'b0;
    v_idx   = ptr_i;
    for (int i = 0; i < N; i++) begin
      if (!v_found && req_i[v_idx]) begin
        gnt_o[v_idx] = 1'b1;
        v_found      = 1'b1;
      end
      v_idx = (v_idx == PW'(N - 1)) ? '0 : v_idx + PW'(1);
    end
  end

endmodule

// File: rtl/db_ram_arb.sv
// Round-robin, burst-locking arbiter for port A of the deblocking SRAM.
// Grants and strobes are combinational; read data returns one cycle later with a registered tag.
module db_ram_arb
  import db_ram_arb_pkg::*;
#(
  parameter int REQ_NUM    = 3,
  parameter int ADDR_WIDTH = DB_RAM_AW,
  parameter int WORD_WIDTH = DB_RAM_DW,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REQ_NUM-1:0]            req_i,
  input  logic [REQ_NUM-1:0]            we_i,
  input  logic [REQ_NUM-1:0]            last_i,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] addr_i,
  input  logic [REQ_NUM*WORD_WIDTH-1:0] wdata_i,
  output logic [REQ_NUM-1:0]            gnt_o,
  output logic [REQ_NUM-1:0]            rvalid_o,
  output logic [WORD_WIDTH-1:0]         rdata_o,
  output logic                          cena_o,
  output logic                          oena_o,
  output logic                          wena_o,
  output logic [ADDR_WIDTH-1:0]         addra_o,
  output logic [WORD_WIDTH-1:0]         dataa_o,
  input  logic [WORD_WIDTH-1:0]         dataa_i
);

  localparam int PW = idx_width(REQ_NUM);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t            r_state;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         r_owner;
  logic [CW-1:0]         r_beat_cnt;
  logic [REQ_NUM-1:0]    r_rvalid;
  logic [ADDR_WIDTH-1:0] r_addra;
  logic [WORD_WIDTH-1:0] r_dataa;

  logic [REQ_NUM-1:0]    w_pick;
  logic [REQ_NUM-1:0]    w_gnt;
  logic [PW-1:0]         w_gidx;
  logic [PW-1:0]         w_ptr_next;
  logic                  w_any;
  logic                  w_we;
  logic                  w_last;
  logic                  w_release;
  logic [CW-1:0]         w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_addr_arr [REQ_NUM];
  logic [WORD_WIDTH-1:0] w_wdata_arr [REQ_NUM];

  rr_pick #(
    .N  (REQ_NUM),
    .PW (PW)
  ) u_rr_pick (
    .req_i (req_i),
    .ptr_i (r_rr_ptr),
    .gnt_o (w_pick)
  );

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_slice
    assign w_addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_arr[gi] = wdata_i[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  // A locked owner is the only candidate; reset masks every grant so no strobe fires.
  always_comb begin
    w_gnt = '0;
    if (!rst) begin
      if (r_state == ST_IDLE) w_gnt = w_pick;
      else                    w_gnt[r_owner] = req_i[r_owner];
    end
  end

  for (genvar bi = 0; bi < PW; bi++) begin : g_enc
    logic [REQ_NUM-1:0] w_sel;
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_bit
      assign w_sel[gi] = (((gi >> bi) & 1) != 0) ? w_gnt[gi] : 1'b0;
    end
    assign w_gidx[bi] = |w_sel;
  end

  assign w_any      = |w_gnt;
  assign w_we       = we_i[w_gidx];
  assign w_last     = last_i[w_gidx];
  assign w_ptr_next = (w_gidx == PW'(REQ_NUM - 1)) ? '0 : w_gidx + PW'(1);
  assign w_cnt_inc  = (r_beat_cnt == CW'(MAX_BURST)) ? r_beat_cnt : r_beat_cnt + CW'(1);
  assign w_release  = w_last || (w_cnt_inc == CW'(MAX_BURST));

  assign gnt_o    = w_gnt;
  assign cena_o   = ~w_any;
  assign wena_o   = ~(w_any & w_we);
  assign oena_o   = ~(w_any & ~w_we);
  assign addra_o  = w_any ? w_addr_arr[w_gidx] : r_addra;
  assign dataa_o  = w_any ? w_wdata_arr[w_gidx] : r_dataa;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = dataa_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= '0;
      r_addra    <= '0;
      r_dataa    <= '0;
    end else begin
      r_rvalid <= w_gnt & ~we_i;
      if (w_any) begin
        r_addra <= w_addr_arr[w_gidx];
        r_dataa <= w_wdata_arr[w_gidx];
        // Hitting MAX_BURST releases the lock exactly like a last beat does.
        if (w_release) begin
          r_state    <= ST_IDLE;
          r_rr_ptr   <= w_ptr_next;
          r_beat_cnt <= '0;
        end else begin
          r_state    <= ST_LOCK;
          r_owner    <= w_gidx;
          r_beat_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_db_ram_arb.sv
// Table-driven bench for db_ram_arb with a read-data scoreboard and an SRAM model on port A.
module tb_db_ram_arb;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, we_i, last_i, gnt_o, rvalid_o;
  logic [N*AW-1:0] addr_i;
  logic [N*DW-1:0] wdata_i;
  logic [DW-1:0]   rdata_o, dataa_o, dataa_i;
  logic            cena_o, oena_o, wena_o;
  logic [AW-1:0]   addra_o;

  typedef struct {
    string        name;
    logic [N-1:0] req, we, last;
    logic [AW-1:0] a0, a1, a2;
    logic [31:0]  seed;
    logic [N-1:0] exp_gnt;
  } vec_t;

  typedef struct {
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          vecs[$];
  sb_t           sb_q[$];
  logic [DW-1:0] sram    [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] sram_q = '0;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            n_vec = 0;
  int            n_err = 0;

  db_ram_arb #(
    .REQ_NUM    (N),
    .ADDR_WIDTH (AW),
    .WORD_WIDTH (DW),
    .MAX_BURST  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .last_i   (last_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .cena_o   (cena_o),
    .oena_o   (oena_o),
    .wena_o   (wena_o),
    .addra_o  (addra_o),
    .dataa_o  (dataa_o),
    .dataa_i  (dataa_i)
  );

  always #5 clk = ~clk;

  // Single-port SRAM model with a registered read.
  always @(posedge clk) begin
    if (!cena_o && !wena_o) sram[addra_o] <= dataa_o;
    if (!cena_o && !oena_o) sram_q <= sram[addra_o];
  end
  assign dataa_i = sram_q;

  function automatic logic [DW-1:0] wd(input logic [31:0] seed, input int k, input logic [AW-1:0] a);
    return {seed, seed ^ 32'(a), seed ^ 32'(k), ~seed};
  endfunction

  function automatic vec_t mk(input string name, input logic [N-1:0] req, input logic [N-1:0] we,
                              input logic [N-1:0] last, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [31:0] seed, input logic [N-1:0] eg);
    vec_t v;
    v.name = name; v.req = req; v.we = we; v.last = last;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.seed = seed; v.exp_gnt = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_i   = v.req;
    we_i    = v.we;
    last_i  = v.last;
    addr_i  = {v.a2, v.a1, v.a0};
    wdata_i = {wd(v.seed, 2, v.a2), wd(v.seed, 1, v.a1), wd(v.seed, 0, v.a0)};
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " gnt"}, DW'(gnt_o), '0);
    chk({name, " strobes"}, DW'({cena_o, oena_o, wena_o}), DW'(3'b111));
    chk({name, " addra"}, DW'(addra_o), '0);
    chk({name, " dataa"}, dataa_o, '0);
    chk({name, " rvalid"}, DW'(rvalid_o), '0);
    chk({name, " rdata"}, rdata_o, sram_q);
    $display("%-6s rst=%b req=%b gnt=%b rvalid=%b", name, rst, req_i, gnt_o, rvalid_o);
  endtask

  task automatic check_cycle(input string name, input logic [N-1:0] exp_gnt);
    int  g;
    sb_t e;
    logic exp_we;
    g = -1;
    for (int k = 0; k < N; k++) if (exp_gnt[k]) g = k;
    exp_we = (g >= 0) ? we_i[g] : 1'b0;
    if (g >= 0) begin
      exp_addr = addr_i[g*AW +: AW];
      exp_data = wdata_i[g*DW +: DW];
    end
    chk({name, " gnt"}, DW'(gnt_o), DW'(exp_gnt));
    chk({name, " strobes"}, DW'({cena_o, oena_o, wena_o}),
        DW'({g < 0, !(g >= 0 && !exp_we), !(g >= 0 && exp_we)}));
    chk({name, " addra"}, DW'(addra_o), DW'(exp_addr));
    chk({name, " dataa"}, dataa_o, exp_data);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({name, " rvalid"}, DW'(rvalid_o), DW'(e.tag));
      chk({name, " rdata"}, rdata_o, e.data);
    end else begin
      chk({name, " rvalid"}, DW'(rvalid_o), '0);
    end
    if (g >= 0) begin
      if (exp_we) ref_mem[exp_addr] = exp_data;
      else begin
        e.tag  = exp_gnt;
        e.data = ref_mem[exp_addr];
        sb_q.push_back(e);
      end
    end
    $display("%-6s req=%b we=%b last=%b gnt=%b addra=%0d rvalid=%b", name, req_i, we_i, last_i,
             gnt_o, addra_o, rvalid_o);
  endtask

  // Called one time unit after a rising edge; leaves one unit after the next.
  task automatic apply_vec(input vec_t v);
    drive(v);
    #3;
    check_cycle(v.name, v.exp_gnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    exp_addr = '0;
    exp_data = '0;

    vecs.push_back(mk("wr3",  3'b001, 3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 32'hA5A5_A5A5, 3'b001));
    vecs.push_back(mk("rd3",  3'b001, 3'b000, 3'b001, 5'd3, 5'd0, 5'd0, 32'h0,        3'b001));
    vecs.push_back(mk("idle", 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0,        3'b000));
    vecs.push_back(mk("wr12", 3'b100, 3'b100, 3'b100, 5'd0, 5'd0, 5'd12, 32'h1200_0000, 3'b100));
    vecs.push_back(mk("rr0",  3'b111, 3'b000, 3'b111, 5'd2, 5'd3, 5'd12, 32'h0, 3'b001));
    vecs.push_back(mk("rr1",  3'b111, 3'b000, 3'b111, 5'd2, 5'd3, 5'd12, 32'h0, 3'b010));
    vecs.push_back(mk("rr2",  3'b111, 3'b000, 3'b111, 5'd2, 5'd3, 5'd12, 32'h0, 3'b100));
    vecs.push_back(mk("rr3",  3'b111, 3'b000, 3'b111, 5'd2, 5'd3, 5'd12, 32'h0, 3'b001));
    vecs.push_back(mk("wr20", 3'b100, 3'b100, 3'b100, 5'd0, 5'd0, 5'd20, 32'h2000_0020, 3'b100));
    for (int a = 0; a < 4; a++)
      vecs.push_back(mk("lock", 3'b011, 3'b011, (a == 3) ? 3'b001 : 3'b000, 5'(a), 5'd7, 5'd0,
                        32'hB0B0_0000, 3'b001));
    vecs.push_back(mk("wait1", 3'b010, 3'b010, 3'b010, 5'd0, 5'd7, 5'd0, 32'hB0B0_0000, 3'b010));
    for (int a = 0; a < 4; a++)
      vecs.push_back(mk("rback", 3'b001, 3'b000, (a == 3) ? 3'b001 : 3'b000, 5'(a), 5'd0, 5'd0,
                        32'h0, 3'b001));
    vecs.push_back(mk("raw",  3'b010, 3'b010, 3'b010, 5'd0, 5'd3, 5'd0, 32'hD00D_0003, 3'b010));
    vecs.push_back(mk("rd3b", 3'b001, 3'b000, 3'b001, 5'd3, 5'd0, 5'd0, 32'h0, 3'b001));
    vecs.push_back(mk("idle", 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000));
    vecs.push_back(mk("stl0", 3'b001, 3'b001, 3'b000, 5'd8, 5'd9, 5'd0, 32'hE0E0_0000, 3'b001));
    for (int c = 0; c < 3; c++)
      vecs.push_back(mk("stall", 3'b010, 3'b000, 3'b000, 5'd8, 5'd9, 5'd0, 32'hE0E0_0000, 3'b000));
    vecs.push_back(mk("stl1", 3'b011, 3'b001, 3'b001, 5'd9, 5'd9, 5'd0, 32'hE0E0_0000, 3'b001));
    vecs.push_back(mk("rd9",  3'b010, 3'b000, 3'b010, 5'd9, 5'd9, 5'd0, 32'hE0E0_0000, 3'b010));
    vecs.push_back(mk("idle", 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000));
    vecs.push_back(mk("frc",  3'b001, 3'b001, 3'b000, 5'd16, 5'd0, 5'd30, 32'hF0F0_0000, 3'b001));
    for (int a = 17; a <= 23; a++)
      vecs.push_back(mk("frc", 3'b101, 3'b101, 3'b000, 5'(a), 5'd0, 5'd30, 32'hF0F0_0000, 3'b001));
    vecs.push_back(mk("frc2", 3'b101, 3'b101, 3'b100, 5'd24, 5'd0, 5'd30, 32'hF0F0_0000, 3'b100));
    for (int a = 24; a <= 27; a++)
      vecs.push_back(mk("frcr", 3'b001, 3'b001, (a == 27) ? 3'b001 : 3'b000, 5'(a), 5'd0, 5'd30,
                        32'hF0F0_0000, 3'b001));
    vecs.push_back(mk("idle", 3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000));

    // Reset state while every requester is asking.
    rst = 1'b1;
    drive(mk("rst", 3'b111, 3'b000, 3'b111, 5'd1, 5'd2, 5'd3, 32'h5555_0000, 3'b000));
    @(posedge clk);
    #1;
    drive(mk("rst", 3'b111, 3'b000, 3'b111, 5'd1, 5'd2, 5'd3, 32'h5555_0000, 3'b000));
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Reset lands during beat 2 of a read burst.
    apply_vec(mk("rdb1", 3'b001, 3'b000, 3'b000, 5'd5, 5'd0, 5'd6, 32'h6060_0000, 3'b001));
    drive(mk("rdb2", 3'b001, 3'b000, 3'b000, 5'd6, 5'd0, 5'd6, 32'h6060_0000, 3'b000));
    #1;
    rst = 1'b1;
    #2;
    sb_q.delete();
    exp_addr = '0;
    exp_data = '0;
    check_reset_outputs("rstmid");
    @(posedge clk);
    #1;
    #3;
    check_reset_outputs("rstnxt");
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_vec(mk("post2", 3'b100, 3'b100, 3'b100, 5'd5, 5'd0, 5'd6, 32'h6060_0000, 3'b100));
    apply_vec(mk("post0", 3'b101, 3'b000, 3'b101, 5'd5, 5'd0, 5'd6, 32'h6060_0000, 3'b001));
    apply_vec(mk("rd6",   3'b100, 3'b000, 3'b100, 5'd5, 5'd0, 5'd6, 32'h6060_0000, 3'b100));
    apply_vec(mk("idle",  3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 3'b000));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
